// File: rtl/stream_minmax_tracker_pkg.sv
// Shared types and constants for the stream min/max tracker.
// Also holds the 2-bit compare cell used by the comparator tree.
package stream_minmax_tracker_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {gt, eq} for two 2-bit unsigned operands.
  function automatic logic [1:0] cmp2(input logic [1:0] a, input logic [1:0] b);
    logic gt;
    logic eq;
    gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
    eq = (a == b);
    return {gt, eq};
  endfunction

endpackage

// File: rtl/stream_minmax_tracker_mag_cmp.sv
// Combinational unsigned magnitude comparator: 2-bit cells merged
// MSB-first in a balanced tree.
module mag_cmp
  import stream_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_gt,
  output logic             o_eq
);

  localparam int NCELL  = (WIDTH + 1) / 2;
  localparam int LVLS   = $clog2(NCELL);
  localparam int LEAVES = 1 << LVLS;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [2*LEAVES-1:0] w_a_pad;
  logic [2*LEAVES-1:0] w_b_pad;
  logic [NODES-1:0]    w_gt;
  logic [NODES-1:0]    w_eq;
  logic [1:0]          w_cell;

  // Heap-ordered tree: left child is the more significant half, so a
  // decided upper half overrides the lower one. Zero padding compares equal.
  always_comb begin
    w_a_pad            = '0;
    w_b_pad            = '0;
    w_a_pad[WIDTH-1:0] = i_a;
    w_b_pad[WIDTH-1:0] = i_b;
    w_gt               = '0;
    w_eq               = '0;
    w_cell             = 2'b00;
    for (int j = 0; j < LEAVES; j++) begin
      w_cell = cmp2(w_a_pad[2*(LEAVES-1-j) +: 2], w_b_pad[2*(LEAVES-1-j) +: 2]);
      w_gt[LEAVES-1+j] = w_cell[1];
      w_eq[LEAVES-1+j] = w_cell[0];
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      w_gt[k] = w_gt[2*k+1] | (w_eq[2*k+1] & w_gt[2*k+2]);
      w_eq[k] = w_eq[2*k+1] & w_eq[2*k+2];
    end
  end

  assign o_gt = w_gt[0];
  assign o_eq = w_eq[0];

endmodule

// File: rtl/stream_minmax_tracker.sv
// Tracks running max/min and sample count over a valid/ready packet and
// presents the result on a held valid/ready output port.
module stream_minmax_tracker
  import stream_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_max,
  output logic [WIDTH-1:0] o_out_min,
  output logic [CNT_W-1:0] o_out_count,
  output logic             o_out_all_eq,
  output logic             o_out_ovf
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;

  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [CNT_W-1:0] r_count;
  logic             r_all_eq;
  logic             r_ovf;
  logic [WIDTH-1:0] w_max_nxt;
  logic [WIDTH-1:0] w_min_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_all_eq_nxt;
  logic             w_ovf_nxt;

  logic             w_accept;
  logic             w_gt_max;
  logic             w_eq_max;
  logic             w_gt_min;
  logic             w_eq_min;
  logic             w_lt_min;

  assign w_accept = i_in_valid & r_in_ready;
  assign w_lt_min = ~w_gt_min & ~w_eq_min;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .i_a  (i_in_data),
    .i_b  (r_max),
    .o_gt (w_gt_max),
    .o_eq (w_eq_max)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .i_a  (i_in_data),
    .i_b  (r_min),
    .o_gt (w_gt_min),
    .o_eq (w_eq_min)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = i_in_last ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they are registered
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE, ST_RUN: begin
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
      ST_DONE: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b1;
      end
      default: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Datapath next values; all-equal survives only while every sample matches
  always_comb begin
    w_max_nxt    = r_max;
    w_min_nxt    = r_min;
    w_count_nxt  = r_count;
    w_all_eq_nxt = r_all_eq;
    w_ovf_nxt    = r_ovf;
    if (w_accept && (r_state == ST_IDLE)) begin
      w_max_nxt    = i_in_data;
      w_min_nxt    = i_in_data;
      w_count_nxt  = L_CNT_ONE;
      w_all_eq_nxt = 1'b1;
      w_ovf_nxt    = 1'b0;
    end else if (w_accept && (r_state == ST_RUN)) begin
      w_max_nxt    = w_gt_max ? i_in_data : r_max;
      w_min_nxt    = w_lt_min ? i_in_data : r_min;
      w_all_eq_nxt = r_all_eq & w_eq_max & w_eq_min;
      if (r_count == L_CNT_MAX) begin
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b1;
      end else begin
        w_count_nxt = r_count + L_CNT_ONE;
        w_ovf_nxt   = r_ovf;
      end
    end else begin
      w_max_nxt    = r_max;
      w_min_nxt    = r_min;
      w_count_nxt  = r_count;
      w_all_eq_nxt = r_all_eq;
      w_ovf_nxt    = r_ovf;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max    <= '0;
      r_min    <= '0;
      r_count  <= '0;
      r_all_eq <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_max    <= w_max_nxt;
      r_min    <= w_min_nxt;
      r_count  <= w_count_nxt;
      r_all_eq <= w_all_eq_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_max    = r_max;
  assign o_out_min    = r_min;
  assign o_out_count  = r_count;
  assign o_out_all_eq = r_all_eq;
  assign o_out_ovf    = r_ovf;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed bench for stream_minmax_tracker: default and CNT_W=3 instances
// plus a standalone comparator for an exhaustive sweep.
module tb_stream_minmax_tracker;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_last, out_ready;
  logic [5:0] in_data;
  logic       in_ready, out_valid, out_all_eq, out_ovf;
  logic [5:0] out_max, out_min;
  logic [7:0] out_count;

  logic       s_valid, s_last, s_oready;
  logic [5:0] s_data;
  logic       s_iready, s_ovalid, s_all_eq, s_ovf;
  logic [5:0] s_max, s_min;
  logic [2:0] s_count;

  logic [5:0] c_a, c_b;
  logic       c_gt, c_eq;

  int checks = 0;
  int errors = 0;

  stream_minmax_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_last(in_last),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_max(out_max), .o_out_min(out_min), .o_out_count(out_count),
    .o_out_all_eq(out_all_eq), .o_out_ovf(out_ovf)
  );

  stream_minmax_tracker #(.WIDTH(6), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(s_valid), .o_in_ready(s_iready), .i_in_data(s_data), .i_in_last(s_last),
    .o_out_valid(s_ovalid), .i_out_ready(s_oready),
    .o_out_max(s_max), .o_out_min(s_min), .o_out_count(s_count),
    .o_out_all_eq(s_all_eq), .o_out_ovf(s_ovf)
  );

  mag_cmp #(.WIDTH(6)) u_cmp (.i_a(c_a), .i_b(c_b), .o_gt(c_gt), .o_eq(c_eq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] d, input logic l);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [5:0] mx, input logic [5:0] mn,
                            input logic [7:0] cnt, input logic eq, input logic ov);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_max"}, {26'd0, out_max}, {26'd0, mx});
    chk({tag, "_min"}, {26'd0, out_min}, {26'd0, mn});
    chk({tag, "_count"}, {24'd0, out_count}, {24'd0, cnt});
    chk({tag, "_all_eq"}, {31'd0, out_all_eq}, {31'd0, eq});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ov});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 6'd0; out_ready = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 6'd0; s_oready = 1'b0;
    c_a = 6'd0; c_b = 6'd0;
    repeat (3) step();

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_max", {26'd0, out_max}, 32'd0);
    chk("rst_min", {26'd0, out_min}, 32'd0);
    chk("rst_count", {24'd0, out_count}, 32'd0);
    chk("rst_all_eq", {31'd0, out_all_eq}, 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Packet 5,12,3,12,7 with result held for 3 cycles
    send(6'd5, 1'b0);
    send(6'd12, 1'b0);
    send(6'd3, 1'b0);
    send(6'd12, 1'b0);
    send(6'd7, 1'b1);
    chk_result("p1", 6'd12, 6'd3, 8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("p1_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("p1_hold_max", {26'd0, out_max}, 32'd12);
      chk("p1_hold_min", {26'd0, out_min}, 32'd3);
      chk("p1_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    release_result();

    // Single-sample packet at the top value
    send(6'd63, 1'b1);
    chk_result("single", 6'd63, 6'd63, 8'd1, 1'b1, 1'b0);
    release_result();

    // Equal samples with 2-cycle gaps
    for (int i = 0; i < 4; i++) begin
      send(6'd9, (i == 3) ? 1'b1 : 1'b0);
      if (i < 3) begin
        repeat (2) begin
          step();
          chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
          chk("gap_out_valid", {31'd0, out_valid}, 32'd0);
        end
      end
    end
    chk_result("eq9", 6'd9, 6'd9, 8'd4, 1'b1, 1'b0);
    release_result();

    // Extremes
    send(6'd0, 1'b0);
    send(6'd63, 1'b0);
    send(6'd0, 1'b0);
    send(6'd63, 1'b1);
    chk_result("ext", 6'd63, 6'd0, 8'd4, 1'b0, 1'b0);
    release_result();

    // Exhaustive comparator sweep
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        c_a = a[5:0];
        c_b = b[5:0];
        #1;
        chk("cmp_gt", {31'd0, c_gt}, (a > b) ? 32'd1 : 32'd0);
        chk("cmp_eq", {31'd0, c_eq}, (a == b) ? 32'd1 : 32'd0);
      end
    end

    // Counter saturation with CNT_W=3
    for (int i = 0; i < 10; i++) begin
      chk("sat_in_ready", {31'd0, s_iready}, 32'd1);
      s_valid = 1'b1;
      s_data  = 6'd1;
      s_last  = (i == 9) ? 1'b1 : 1'b0;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("sat_valid", {31'd0, s_ovalid}, 32'd1);
    chk("sat_count", {29'd0, s_count}, 32'd7);
    chk("sat_ovf", {31'd0, s_ovf}, 32'd1);
    chk("sat_max", {26'd0, s_max}, 32'd1);
    chk("sat_min", {26'd0, s_min}, 32'd1);
    chk("sat_all_eq", {31'd0, s_all_eq}, 32'd1);

    // Asynchronous reset mid-packet
    send(6'd30, 1'b0);
    send(6'd2, 1'b0);
    send(6'd40, 1'b0);
    chk("mid_count", {24'd0, out_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_max", {26'd0, out_max}, 32'd0);
    chk("arst_min", {26'd0, out_min}, 32'd0);
    chk("arst_count", {24'd0, out_count}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_sat_ovf", {31'd0, s_ovf}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send(6'd20, 1'b0);
    send(6'd4, 1'b1);
    chk_result("after_rst", 6'd20, 6'd4, 8'd2, 1'b0, 1'b0);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
